// File: rtl/detector_choque.sv
// detector_choque -- bird/pipe collision detector with lives and invulnerability.
//
// On iFrameTick (IDLE only) the pipe positions and bird Y are snapshotted; the
// snapshot is then scanned one pipe per cycle, followed by a single EVAL cycle
// that applies the frame's verdict to lives / invulnerability. Tick to oDone
// latency is N_PIPES+1 cycles. Losing the last life parks the FSM in DEAD
// until iRestart.
//
// Ports:
//   iClk, iReset_n        clock, async active-low reset
//   iFrameTick            start-of-evaluation pulse (dropped outside IDLE)
//   iRestart              synchronous new-game pulse, beats a simultaneous tick
//   iPosXBus / iPosYBus   pipe k X at [10k+9:10k], gap-top Y at [9k+8:9k]
//   iPosYC                bird Y
//   oStop                 game over (level)
//   oHit / oDone          one-cycle pulses in EVAL
//   oLives                remaining lives
//   oHitIdx               lowest colliding pipe of the last colliding frame
//
// Build option: define CHOQUE_FLOOR_EN to also count floor/ceiling contact
// (YC >= FLOOR_Y or YC == 0) as a collision during EVAL.

// Per-pipe collision compare on the snapshot.
module detector_choque_lane #(
  parameter int BIRD_X_MIN = 63,
  parameter int BIRD_X_MAX = 160,
  parameter int GAP_H      = 96
) (
  input  logic [9:0] iPosX,
  input  logic [8:0] iPosY,
  input  logic [8:0] iPosYC,
  output logic       oHit
);
  logic [9:0] gapBot;
  logic       inCol;
  logic       outGap;

  // 10-bit sum: 511 + GAP_H cannot wrap for any sane gap height.
  assign gapBot = {1'b0, iPosY} + 10'(GAP_H);
  assign inCol  = (int'(iPosX) > BIRD_X_MIN) && (int'(iPosX) < BIRD_X_MAX);
  assign outGap = (iPosYC <= iPosY) || ({1'b0, iPosYC} >= gapBot);
  assign oHit   = inCol && outGap;
endmodule

module detector_choque #(
  parameter int N_PIPES      = 4,
  parameter int BIRD_X_MIN   = 63,
  parameter int BIRD_X_MAX   = 160,
  parameter int GAP_H        = 96,
  parameter int LIVES        = 3,
  parameter int INVUL_FRAMES = 30,
  parameter int FLOOR_Y      = 460,
  localparam int IW          = (N_PIPES > 1) ? $clog2(N_PIPES) : 1
) (
  input  logic                 iClk,
  input  logic                 iReset_n,
  input  logic                 iFrameTick,
  input  logic                 iRestart,
  input  logic [N_PIPES*10-1:0] iPosXBus,
  input  logic [N_PIPES*9-1:0]  iPosYBus,
  input  logic [8:0]           iPosYC,
  output logic                 oStop,
  output logic                 oHit,
  output logic                 oDone,
  output logic [2:0]           oLives,
  output logic [IW-1:0]        oHitIdx
);
  typedef enum logic [1:0] {IDLE, SCAN, EVAL, DEAD} state_t;

  localparam logic [IW-1:0] IDX_LAST = IW'(N_PIPES - 1);

  state_t                     state, stateNxt;
  logic [N_PIPES-1:0][9:0]    xSnap;
  logic [N_PIPES-1:0][8:0]    ySnap;
  logic [8:0]                 ycSnap;
  logic [IW-1:0]              idx;
  logic [IW-1:0]              hitIdx;
  logic                       collFlag;
  logic [7:0]                 invul;
  logic [2:0]                 lives;
  logic [N_PIPES-1:0]         laneHit;
  logic                       floorHit;
  logic                       hitNow;

  for (genvar k = 0; k < N_PIPES; k++) begin : gLane
    detector_choque_lane #(
      .BIRD_X_MIN(BIRD_X_MIN), .BIRD_X_MAX(BIRD_X_MAX), .GAP_H(GAP_H)
    ) uLane (
      .iPosX (xSnap[k]),
      .iPosY (ySnap[k]),
      .iPosYC(ycSnap),
      .oHit  (laneHit[k])
    );
  end

`ifdef CHOQUE_FLOOR_EN
  assign floorHit = (int'(ycSnap) >= FLOOR_Y) || (ycSnap == 9'd0);
`else
  assign floorHit = 1'b0;
`endif

  // Hits are only scored once the invulnerability window has run out.
  assign hitNow = (state == EVAL) && (collFlag || floorHit) && (invul == 8'd0);

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (iFrameTick) stateNxt = SCAN;
      SCAN:    if (idx == IDX_LAST) stateNxt = EVAL;
      EVAL:    stateNxt = (hitNow && lives == 3'd1) ? DEAD : IDLE;
      DEAD:    stateNxt = DEAD;
      default: stateNxt = IDLE;
    endcase
    if (iRestart) stateNxt = IDLE;
  end

  // Pulses are masked by iRestart so a restart landing on EVAL wins outright.
  assign oDone   = (state == EVAL) && !iRestart;
  assign oHit    = hitNow && !iRestart;
  assign oStop   = (state == DEAD);
  assign oLives  = lives;
  assign oHitIdx = hitIdx;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state    <= IDLE;
      xSnap    <= '0;
      ySnap    <= '0;
      ycSnap   <= '0;
      idx      <= '0;
      hitIdx   <= '0;
      collFlag <= 1'b0;
      invul    <= 8'd0;
      lives    <= 3'(LIVES);
    end else begin
      state <= stateNxt;
      if (iRestart) begin
        idx      <= '0;
        collFlag <= 1'b0;
        invul    <= 8'd0;
        lives    <= 3'(LIVES);
      end else begin
        case (state)
          IDLE: if (iFrameTick) begin
            for (int k = 0; k < N_PIPES; k++) begin
              xSnap[k] <= iPosXBus[10*k +: 10];
              ySnap[k] <= iPosYBus[9*k +: 9];
            end
            ycSnap   <= iPosYC;
            idx      <= '0;
            collFlag <= 1'b0;
          end
          SCAN: begin
            // First collider of the frame wins; hitIdx keeps the old frame's
            // value when nothing collides this time.
            if (laneHit[idx]) begin
              collFlag <= 1'b1;
              if (!collFlag) hitIdx <= idx;
            end
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end
          EVAL: begin
            if (hitNow) begin
              lives <= lives - 3'd1;
              invul <= 8'(INVUL_FRAMES);
            end else if (invul != 8'd0) begin
              invul <= invul - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_detector_choque.sv
module tb_detector_choque;
  localparam int N    = 4;
  localparam int XMIN = 63;
  localparam int XMAX = 160;
  localparam int GAP  = 96;
  localparam int LIV  = 3;
  localparam int INV  = 30;
  localparam int FLY  = 460;

  logic           iClk = 1'b0;
  logic           iReset_n = 1'b0;
  logic           iFrameTick = 1'b0;
  logic           iRestart = 1'b0;
  logic [N*10-1:0] iPosXBus = '0;
  logic [N*9-1:0]  iPosYBus = '0;
  logic [8:0]     iPosYC = '0;
  logic           oStop, oHit, oDone;
  logic [2:0]     oLives;
  logic [1:0]     oHitIdx;

  detector_choque #(
    .N_PIPES(N), .BIRD_X_MIN(XMIN), .BIRD_X_MAX(XMAX), .GAP_H(GAP),
    .LIVES(LIV), .INVUL_FRAMES(INV), .FLOOR_Y(FLY)
  ) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iFrameTick(iFrameTick), .iRestart(iRestart),
    .iPosXBus(iPosXBus), .iPosYBus(iPosYBus), .iPosYC(iPosYC),
    .oStop(oStop), .oHit(oHit), .oDone(oDone), .oLives(oLives), .oHitIdx(oHitIdx)
  );

  always #5 iClk = ~iClk;

  int nChecks = 0;
  int nFails  = 0;

  // Game-level reference model
  int mLives  = LIV;
  int mInvul  = 0;
  int mHitIdx = 0;
  bit mDead   = 0;

  function automatic logic [N*10-1:0] mkX(input int x0, x1, x2, x3);
    logic [N*10-1:0] b;
    b[9:0] = 10'(x0); b[19:10] = 10'(x1); b[29:20] = 10'(x2); b[39:30] = 10'(x3);
    return b;
  endfunction

  function automatic logic [N*9-1:0] mkY(input int y0, y1, y2, y3);
    logic [N*9-1:0] b;
    b[8:0] = 9'(y0); b[17:9] = 9'(y1); b[26:18] = 9'(y2); b[35:27] = 9'(y3);
    return b;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic do_frame(input logic [N*10-1:0] xb, input logic [N*9-1:0] yb,
                          input logic [8:0] yc, input string tag);
    bit coll = 0;
    int first = -1;
    bit expHit;
    bit got = 0;
    int lat = 0;
    for (int k = 0; k < N; k++) begin
      int x = int'(xb[10*k +: 10]);
      int y = int'(yb[9*k +: 9]);
      if (x > XMIN && x < XMAX && (int'(yc) <= y || int'(yc) >= y + GAP)) begin
        coll = 1;
        if (first < 0) first = k;
      end
    end
`ifdef CHOQUE_FLOOR_EN
    if (int'(yc) >= FLY || yc == 9'd0) coll = 1;
`endif
    expHit = coll && (mInvul == 0);

    iPosXBus = xb; iPosYBus = yb; iPosYC = yc; iFrameTick = 1'b1;
    @(negedge iClk);
    iFrameTick = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      if (oDone) begin got = 1; lat = c; break; end
      @(negedge iClk);
    end

    if (mDead) begin
      nChecks++;
      if (got || oStop !== 1'b1 || oLives !== 3'd0) begin
        nFails++;
        $display("FAIL %s dead: oDone seen=%0b oStop=%0b oLives=%0d, required 0/1/0", tag, got, oStop, oLives);
      end
      return;
    end

    nChecks++;
    if (!got || lat != N + 1) begin
      nFails++;
      $display("FAIL %s latency: seen=%0b lat=%0d, required %0d", tag, got, lat, N + 1);
    end
    nChecks++;
    if (oHit !== expHit) begin
      nFails++;
      $display("FAIL %s oHit: got %0b, required %0b", tag, oHit, expHit);
    end

    if (expHit) begin
      mLives--; mInvul = INV;
    end else if (mInvul > 0) mInvul--;
    if (first >= 0) mHitIdx = first;
    if (mLives == 0) mDead = 1;

    if (got) @(negedge iClk);
    nChecks++;
    if (oLives !== 3'(mLives) || oStop !== mDead || oHitIdx !== 2'(mHitIdx) || oDone !== 1'b0) begin
      nFails++;
      $display("FAIL %s post: lives=%0d stop=%0b idx=%0d done=%0b, required %0d/%0b/%0d/0",
               tag, oLives, oStop, oHitIdx, oDone, mLives, mDead, mHitIdx);
    end
  endtask

  task automatic do_restart();
    iRestart = 1'b1;
    @(negedge iClk);
    iRestart = 1'b0;
    mLives = LIV; mInvul = 0; mDead = 0;
  endtask

  task automatic test_reset();
    @(negedge iClk);
    nChecks++;
    if (oStop !== 1'b0 || oHit !== 1'b0 || oDone !== 1'b0 || oLives !== 3'(LIV) || oHitIdx !== 2'd0) begin
      nFails++;
      $display("FAIL reset: stop=%0b hit=%0b done=%0b lives=%0d idx=%0d, required 0/0/0/%0d/0",
               oStop, oHit, oDone, oLives, oHitIdx, LIV);
    end
    iReset_n = 1'b1;  // first frame ticks on this same negedge
  endtask

  task automatic test_no_collision();
    do_frame(mkX(300, 300, 300, 300), mkY(200, 200, 200, 200), 9'd150, "nocoll");
  endtask

  task automatic test_boundaries();
    do_frame(mkX(63, 300, 300, 300), mkY(200, 200, 200, 200), 9'd0, "x63");
    do_frame(mkX(300, 160, 300, 300), mkY(200, 200, 200, 200), 9'd0, "x160");
    do_frame(mkX(300, 300, 300, 64), mkY(200, 200, 200, 200), 9'd295, "yc295");
    do_frame(mkX(300, 300, 300, 64), mkY(200, 200, 200, 200), 9'd296, "yc296");
  endtask

  task automatic test_hit_invul();
    do_restart();
    do_frame(mkX(300, 300, 100, 300), mkY(0, 0, 200, 0), 9'd150, "hit1");
    for (int i = 0; i < 30; i++)
      do_frame(mkX(300, 300, 100, 300), mkY(0, 0, 200, 0), 9'd150, "invul");
    do_frame(mkX(300, 300, 100, 300), mkY(0, 0, 200, 0), 9'd150, "hit31");
  endtask

  task automatic test_dead();
    for (int i = 0; i < 31; i++)
      do_frame(mkX(100, 300, 300, 300), mkY(200, 0, 0, 0), 9'd150, "todead");
    do_frame(mkX(300, 300, 300, 300), mkY(200, 200, 200, 200), 9'd150, "deadtick");
  endtask

  task automatic test_restart_dead();
    bit seen = 0;
    iRestart = 1'b1; iFrameTick = 1'b1;
    @(negedge iClk);
    iRestart = 1'b0; iFrameTick = 1'b0;
    mLives = LIV; mInvul = 0; mDead = 0;
    nChecks++;
    if (oStop !== 1'b0 || oLives !== 3'(LIV)) begin
      nFails++;
      $display("FAIL restart: stop=%0b lives=%0d, required 0/%0d", oStop, oLives, LIV);
    end
    for (int c = 0; c < N + 3; c++) begin
      if (oDone) seen = 1;
      @(negedge iClk);
    end
    nChecks++;
    if (seen) begin
      nFails++;
      $display("FAIL restart_tick: oDone seen=1, required 0");
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    iPosXBus = mkX(300, 300, 300, 300); iPosYBus = mkY(200, 200, 200, 200); iPosYC = 9'd150;
    iFrameTick = 1'b1;
    repeat (3) @(negedge iClk);
    iFrameTick = 1'b0;
    for (int c = 0; c < 2 * N + 4; c++) begin
      if (oDone) dones++;
      @(negedge iClk);
    end
    if (mInvul > 0) mInvul--;
    nChecks++;
    if (dones != 1) begin
      nFails++;
      $display("FAIL back_to_back: oDone count=%0d, required 1", dones);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [N*10-1:0] xb;
      logic [N*9-1:0]  yb;
      if (mDead) do_restart();
      for (int k = 0; k < N; k++) begin
        xb[10*k +: 10] = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                     : 10'($urandom_range(55, 170));
        yb[9*k +: 9] = 9'($urandom_range(0, 511));
      end
      do_frame(xb, yb, 9'($urandom_range(0, 511)), "random");
    end
  endtask

  task automatic test_reset_midscan();
    bit seen = 0;
    do_restart();
    do_frame(mkX(300, 100, 300, 300), mkY(0, 200, 0, 0), 9'd150, "prereset");
    iPosXBus = mkX(100, 100, 100, 100); iFrameTick = 1'b1;
    @(negedge iClk);
    iFrameTick = 1'b0;
    @(negedge iClk);
    iReset_n = 1'b0;
    #1;
    nChecks++;
    if (oStop !== 1'b0 || oHit !== 1'b0 || oDone !== 1'b0 || oLives !== 3'(LIV) || oHitIdx !== 2'd0) begin
      nFails++;
      $display("FAIL midscan_reset: stop=%0b hit=%0b done=%0b lives=%0d idx=%0d, required 0/0/0/%0d/0",
               oStop, oHit, oDone, oLives, oHitIdx, LIV);
    end
    mLives = LIV; mInvul = 0; mHitIdx = 0; mDead = 0;
    @(negedge iClk);
    iReset_n = 1'b1;
    for (int c = 0; c < N + 3; c++) begin
      if (oDone) seen = 1;
      @(negedge iClk);
    end
    nChecks++;
    if (seen) begin
      nFails++;
      $display("FAIL midscan_done: oDone seen=1, required 0");
    end
    do_frame(mkX(300, 300, 300, 300), mkY(200, 200, 200, 200), 9'd150, "postreset");
`ifdef CHOQUE_FLOOR_EN
    do_frame(mkX(300, 300, 300, 300), mkY(200, 200, 200, 200), 9'd470, "floor");
`endif
  endtask

  initial begin
    test_reset();
    test_no_collision();
    test_boundaries();
    test_hit_invul();
    test_dead();
    test_restart_dead();
    test_back_to_back();
    test_random();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
